// File: rtl/vec_mem_pkg.sv
// Shared state encoding and beat-sizing helpers for the vector memory sequencer.
package vec_mem_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  function automatic int beats(input int lanes, input int beat_lanes);
    return lanes / beat_lanes;
  endfunction

  function automatic int beat_cnt_width(input int n_beats);
    return $clog2(n_beats + 1);
  endfunction

endpackage

// File: rtl/vec_lane_packer.sv
// Read-return path: MEM_LATENCY-deep valid/index pipe that lands each dmem beat in its lane slot.
// rsp_rdata is loaded with the fully assembled vector on the edge that captures the last beat.
module vec_lane_packer
  import vec_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int LANES       = 4,
  parameter int BEAT_LANES  = 2,
  parameter int MEM_LATENCY = 1,
  parameter int BEATS       = beats(LANES, BEAT_LANES),
  parameter int CW          = beat_cnt_width(BEATS)
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_flush,
  input  logic                             i_start,
  input  logic                             i_issue,
  input  logic [CW-1:0]                    i_idx,
  input  logic [BEAT_LANES*DATA_WIDTH-1:0] i_beat,
  output logic                             o_last,
  output logic [LANES*DATA_WIDTH-1:0]      o_rdata
);

  localparam int BW = BEAT_LANES * DATA_WIDTH;

  logic [MEM_LATENCY-1:0]        r_vld;
  logic [CW-1:0]                 r_idx [MEM_LATENCY];
  logic [CW-1:0]                 r_rcnt;
  logic [LANES*DATA_WIDTH-1:0]   r_asm;
  logic [LANES*DATA_WIDTH-1:0]   r_rdata;
  logic [LANES*DATA_WIDTH-1:0]   w_merged;
  logic                          w_cap;

  // Beats still in flight when a flush arrives are dropped rather than captured.
  assign w_cap   = r_vld[MEM_LATENCY-1] && !i_flush;
  assign o_last  = w_cap && (r_rcnt == CW'(BEATS - 1));
  assign o_rdata = r_rdata;

  always_comb begin
    w_merged = r_asm;
    w_merged[int'(r_idx[MEM_LATENCY-1]) * BW +: BW] = i_beat;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld   <= '0;
      for (int s = 0; s < MEM_LATENCY; s++) r_idx[s] <= '0;
      r_rcnt  <= '0;
      r_asm   <= '0;
      r_rdata <= '0;
    end else begin
      r_vld[0] <= i_issue && !i_flush;
      r_idx[0] <= i_idx;
      for (int s = 1; s < MEM_LATENCY; s++) begin
        r_vld[s] <= r_vld[s-1] && !i_flush;
        r_idx[s] <= r_idx[s-1];
      end
      if (i_start)    r_rcnt <= '0;
      else if (w_cap) r_rcnt <= r_rcnt + CW'(1);
      if (w_cap)  r_asm   <= w_merged;
      if (o_last) r_rdata <= w_merged;
    end
  end

endmodule

// File: rtl/vec_mem_sequencer.sv
// Splits one LANES-wide vector load/store into BEAT_LANES-wide dmem beats, one per cycle,
// and returns a single response; stalls the pipeline via busy while an access is open.
module vec_mem_sequencer
  import vec_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int LANES       = 4,
  parameter int BEAT_LANES  = 2,
  parameter int ADDR_WIDTH  = 5,
  parameter int MEM_LATENCY = 1
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [31:0]                      req_addr,
  input  logic [LANES*DATA_WIDTH-1:0]      req_wdata,
  input  logic                             flush,
  output logic                             busy,
  output logic                             rsp_valid,
  output logic                             rsp_err,
  output logic [LANES*DATA_WIDTH-1:0]      rsp_rdata,
  output logic [ADDR_WIDTH-1:0]            dmem_address0,
  output logic                             dmem_ce0,
  output logic                             dmem_we0,
  output logic                             dmem_vec_en,
  output logic [BEAT_LANES*DATA_WIDTH-1:0] dmem_vecd,
  input  logic [BEAT_LANES*DATA_WIDTH-1:0] dmem_vecq
);

  localparam int BEATS = beats(LANES, BEAT_LANES);
  localparam int CW    = beat_cnt_width(BEATS);
  localparam int BW    = BEAT_LANES * DATA_WIDTH;

  generate
    if (LANES % BEAT_LANES != 0) begin : g_bad_lanes
      $error("vec_mem_sequencer: LANES must be a multiple of BEAT_LANES");
    end
    if (MEM_LATENCY < 1 || MEM_LATENCY > 3) begin : g_bad_latency
      $error("vec_mem_sequencer: MEM_LATENCY must be 1..3");
    end
  endgenerate

  state_t                      r_state, w_state_nxt;
  logic [CW-1:0]               r_icnt;
  logic [ADDR_WIDTH-1:0]       r_base;
  logic [LANES*DATA_WIDTH-1:0] r_wdata;
  logic                        r_write, r_err;
  logic                        w_accept, w_misal, w_issue, w_last_issue, w_last_cap;
  logic [ADDR_WIDTH-1:0]       w_off;
  logic                        w_unused_addr;

  assign w_unused_addr = &{1'b0, req_addr[31:ADDR_WIDTH+2]};

  assign req_ready    = (r_state == IDLE);
  assign w_accept     = req_valid && req_ready && !flush;
  assign w_misal      = (req_addr[1:0] != 2'b00);
  assign busy         = (r_state != IDLE) || (req_valid && !flush);
  assign w_issue      = (r_state == ISSUE);
  assign w_last_issue = w_issue && (r_icnt == CW'(BEATS - 1));
  // Address arithmetic stays ADDR_WIDTH wide so the beat address wraps around dmem.
  assign w_off        = ADDR_WIDTH'(int'(r_icnt) * BEAT_LANES);

  assign dmem_ce0      = w_issue;
  assign dmem_vec_en   = w_issue;
  assign dmem_we0      = w_issue && r_write;
  assign dmem_address0 = w_issue ? r_base + w_off : '0;
  assign dmem_vecd     = (w_issue && r_write) ? r_wdata[int'(r_icnt) * BW +: BW] : '0;
  assign rsp_valid     = (r_state == RESP);
  assign rsp_err       = rsp_valid && r_err;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_misal ? RESP : ISSUE;
      ISSUE:   if (w_last_issue) w_state_nxt = r_write ? RESP : DRAIN;
      DRAIN:   if (w_last_cap) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state <= IDLE;
      r_icnt  <= '0;
      r_base  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_icnt  <= '0;
        r_base  <= req_addr[ADDR_WIDTH+1:2];
        r_wdata <= req_wdata;
        r_write <= req_write;
        r_err   <= w_misal;
      end else if (w_issue) begin
        r_icnt <= r_icnt + CW'(1);
      end
    end
  end

  vec_lane_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES),
    .BEAT_LANES (BEAT_LANES),
    .MEM_LATENCY(MEM_LATENCY)
  ) u_packer (
    .i_clk  (ap_clk),
    .i_rst  (ap_rst),
    .i_flush(flush),
    .i_start(w_accept),
    .i_issue(w_issue && !r_write),
    .i_idx  (r_icnt),
    .i_beat (dmem_vecq),
    .o_last (w_last_cap),
    .o_rdata(rsp_rdata)
  );

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench: DUT A (4 lanes, 32-word dmem, latency 1) and DUT B (8 lanes, 8-word dmem, latency 3).
module tb_vec_mem_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic mem_init;

  // DUT A
  logic         rst_a, req_valid_a, req_ready_a, req_write_a, flush_a, busy_a, rsp_valid_a, rsp_err_a;
  logic [31:0]  req_addr_a;
  logic [127:0] req_wdata_a, rsp_rdata_a;
  logic [4:0]   addr_a;
  logic         ce_a, we_a, ven_a;
  logic [63:0]  vecd_a, vecq_a;

  // DUT B
  logic         rst_b, req_valid_b, req_ready_b, req_write_b, flush_b, busy_b, rsp_valid_b, rsp_err_b;
  logic [31:0]  req_addr_b;
  logic [255:0] req_wdata_b, rsp_rdata_b;
  logic [2:0]   addr_b;
  logic         ce_b, we_b, ven_b;
  logic [63:0]  vecd_b, vecq_b;

  vec_mem_sequencer #(.DATA_WIDTH(32), .LANES(4), .BEAT_LANES(2), .ADDR_WIDTH(5), .MEM_LATENCY(1)) u_dut_a (
    .ap_clk(clk), .ap_rst(rst_a), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_write(req_write_a), .req_addr(req_addr_a), .req_wdata(req_wdata_a), .flush(flush_a),
    .busy(busy_a), .rsp_valid(rsp_valid_a), .rsp_err(rsp_err_a), .rsp_rdata(rsp_rdata_a),
    .dmem_address0(addr_a), .dmem_ce0(ce_a), .dmem_we0(we_a), .dmem_vec_en(ven_a),
    .dmem_vecd(vecd_a), .dmem_vecq(vecq_a));

  vec_mem_sequencer #(.DATA_WIDTH(32), .LANES(8), .BEAT_LANES(2), .ADDR_WIDTH(3), .MEM_LATENCY(3)) u_dut_b (
    .ap_clk(clk), .ap_rst(rst_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_write(req_write_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b), .flush(flush_b),
    .busy(busy_b), .rsp_valid(rsp_valid_b), .rsp_err(rsp_err_b), .rsp_rdata(rsp_rdata_b),
    .dmem_address0(addr_b), .dmem_ce0(ce_b), .dmem_we0(we_b), .dmem_vec_en(ven_b),
    .dmem_vecd(vecd_b), .dmem_vecq(vecq_b));

  // dmem models: a beat covers two consecutive words, wrapping at the memory size
  logic [31:0] mem_a [32];
  logic [63:0] q_a;
  int          beats_a = 0;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem_a[i] <= 32'h100 + i;
    end else if (ce_a && we_a) begin
      mem_a[addr_a]              <= vecd_a[31:0];
      mem_a[5'(addr_a + 5'd1)]   <= vecd_a[63:32];
    end
    q_a <= {mem_a[5'(addr_a + 5'd1)], mem_a[addr_a]};
    if (ce_a) beats_a++;
  end
  assign vecq_a = q_a;

  logic [31:0] mem_b [8];
  logic [63:0] q_b [3];
  int          beats_b = 0;
  int          rsps_b = 0;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 8; i++) mem_b[i] <= 32'h200 + i;
    end else if (ce_b && we_b) begin
      mem_b[addr_b]            <= vecd_b[31:0];
      mem_b[3'(addr_b + 3'd1)] <= vecd_b[63:32];
    end
    q_b[0] <= {mem_b[3'(addr_b + 3'd1)], mem_b[addr_b]};
    q_b[1] <= q_b[0];
    q_b[2] <= q_b[1];
    if (ce_b) beats_b++;
    if (rsp_valid_b) rsps_b++;
  end
  assign vecq_b = q_b[2];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         write;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp_rdata;
    logic         exp_err;
    int           exp_lat;
    int           exp_beats;
  } vec_t;

  vec_t vecs [9];

  task automatic run_a(input vec_t v, output int lat, output int nbeats,
                       output logic err, output logic [127:0] rd);
    int b0;
    @(negedge clk);
    req_valid_a = 1'b1; req_write_a = v.write; req_addr_a = v.addr; req_wdata_a = v.wdata;
    b0 = beats_a;
    @(posedge clk);
    #1 req_valid_a = 1'b0;
    lat = -1; err = 1'bx; rd = 'x;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rsp_valid_a) begin
        lat = c; err = rsp_err_a; rd = rsp_rdata_a;
        break;
      end
    end
    nbeats = beats_a - b0;
  endtask

  task automatic run_b(input logic [31:0] addr, output int lat, output logic [255:0] rd);
    @(negedge clk);
    req_valid_b = 1'b1; req_write_b = 1'b0; req_addr_b = addr;
    @(posedge clk);
    #1 req_valid_b = 1'b0;
    lat = -1; rd = 'x;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (rsp_valid_b) begin
        lat = c; rd = rsp_rdata_b;
        break;
      end
    end
  endtask

  localparam logic [255:0] B_LD0  = 256'h00000207_00000206_00000006_00000005_00000004_00000003_00000002_00000001;
  localparam logic [255:0] B_LD10 = 256'h00000004_00000003_00000002_00000001_00000207_00000206_00000006_00000005;

  initial begin
    int lat, nb, b0, r0, gaps, nrsp, rsp1, rsp2, acc2;
    logic err, drop;
    logic [127:0] rd;
    logic [255:0] rdb, rd1, rd2;

    vecs[0] = '{write:1'b0, addr:32'h10, wdata:'0,
                exp_rdata:128'h00000107_00000106_00000105_00000104, exp_err:1'b0, exp_lat:4, exp_beats:2};
    vecs[1] = '{write:1'b1, addr:32'h7C, wdata:128'h00000004_00000003_00000002_00000001,
                exp_rdata:128'h00000107_00000106_00000105_00000104, exp_err:1'b0, exp_lat:3, exp_beats:2};
    vecs[2] = '{write:1'b0, addr:32'h7C, wdata:'0,
                exp_rdata:128'h00000004_00000003_00000002_00000001, exp_err:1'b0, exp_lat:4, exp_beats:2};
    vecs[3] = '{write:1'b0, addr:32'h12, wdata:'0,
                exp_rdata:128'h00000004_00000003_00000002_00000001, exp_err:1'b1, exp_lat:1, exp_beats:0};
    vecs[4] = '{write:1'b0, addr:32'h00, wdata:'0,
                exp_rdata:128'h00000103_00000004_00000003_00000002, exp_err:1'b0, exp_lat:4, exp_beats:2};
    vecs[5] = '{write:1'b1, addr:32'h03, wdata:{4{32'hFFFFFFFF}},
                exp_rdata:128'h00000103_00000004_00000003_00000002, exp_err:1'b1, exp_lat:1, exp_beats:0};
    vecs[6] = '{write:1'b1, addr:32'h20, wdata:128'h000000DD_000000CC_000000BB_000000AA,
                exp_rdata:128'h00000103_00000004_00000003_00000002, exp_err:1'b0, exp_lat:3, exp_beats:2};
    vecs[7] = '{write:1'b0, addr:32'h20, wdata:'0,
                exp_rdata:128'h000000DD_000000CC_000000BB_000000AA, exp_err:1'b0, exp_lat:4, exp_beats:2};
    vecs[8] = '{write:1'b0, addr:32'h00, wdata:'0,
                exp_rdata:128'h00000103_00000004_00000003_00000002, exp_err:1'b0, exp_lat:4, exp_beats:2};

    rst_a = 1'b1; rst_b = 1'b1; mem_init = 1'b1;
    req_valid_a = 1'b0; req_write_a = 1'b0; req_addr_a = '0; req_wdata_a = '0; flush_a = 1'b0;
    req_valid_b = 1'b0; req_write_b = 1'b0; req_addr_b = '0; req_wdata_b = '0; flush_b = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_req_ready", req_ready_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_rsp_valid", rsp_valid_a, 0);
    chk("rst_ce0", ce_a, 0);
    chk("rst_we0", we_a, 0);
    chk("rst_vec_en", ven_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_rdata", rsp_rdata_a, 0);

    rst_a = 1'b0; rst_b = 1'b0; mem_init = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_a(vecs[i], lat, nb, err, rd);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_beats", i), nb, vecs[i].exp_beats);
    end

    // Async reset during a store beat: port strobes drop without a clock edge
    @(negedge clk);
    req_valid_a = 1'b1; req_write_a = 1'b1; req_addr_a = 32'h40; req_wdata_a = {4{32'h55}};
    @(posedge clk);
    #1 req_valid_a = 1'b0;
    @(negedge clk);
    chk("a_issue_ce0", ce_a, 1);
    rst_a = 1'b1;
    #1;
    chk("a_rst_ce0", ce_a, 0);
    chk("a_rst_we0", we_a, 0);
    chk("a_rst_vec_en", ven_a, 0);
    chk("a_rst_ready", req_ready_a, 1);
    @(negedge clk);
    rst_a = 1'b0;

    // B: store of 8 lanes flushed while beat 2 is on the port
    b0 = beats_b; r0 = rsps_b;
    @(negedge clk);
    req_valid_b = 1'b1; req_write_b = 1'b1; req_addr_b = 32'h0;
    req_wdata_b = 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;
    @(posedge clk);
    #1 req_valid_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("b_flush_beat2_addr", addr_b, 4);
    flush_b = 1'b1;
    @(negedge clk);
    flush_b = 1'b0;
    chk("b_flush_ready", req_ready_b, 1);
    chk("b_flush_ce0", ce_b, 0);
    repeat (10) @(negedge clk);
    chk("b_flush_beats", beats_b - b0, 3);
    chk("b_flush_no_rsp", rsps_b - r0, 0);
    chk("b_flush_mem4", mem_b[4], 5);
    chk("b_flush_mem5", mem_b[5], 6);
    chk("b_flush_mem6", mem_b[6], 32'h206);

    // B: two back-to-back loads with the request held valid throughout
    @(negedge clk);
    req_valid_b = 1'b1; req_write_b = 1'b0; req_addr_b = 32'h0;
    @(posedge clk);
    #1 req_addr_b = 32'h10;
    gaps = 0; nrsp = 0; rsp1 = -1; rsp2 = -1; acc2 = -1; drop = 1'b0; rd1 = 'x; rd2 = 'x;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (cyc <= 17 && !busy_b) gaps++;
      if (rsp_valid_b) begin
        if (nrsp == 0) begin rsp1 = cyc; rd1 = rsp_rdata_b; end
        else begin rsp2 = cyc; rd2 = rsp_rdata_b; end
        nrsp++;
      end
      if (drop) begin req_valid_b = 1'b0; drop = 1'b0; end
      if (req_ready_b && req_valid_b) begin acc2 = cyc; drop = 1'b1; end
    end
    chk("b2b_rsp1_cycle", rsp1, 8);
    chk("b2b_accept2_cycle", acc2, 9);
    chk("b2b_rsp2_cycle", rsp2, 17);
    chk("b2b_rdata1", rd1, B_LD0);
    chk("b2b_rdata2", rd2, B_LD10);
    chk("b2b_busy_gaps", gaps, 0);
    chk("b2b_rsp_count", nrsp, 2);

    // B: async reset while draining a load, then a clean load
    r0 = rsps_b;
    @(negedge clk);
    req_valid_b = 1'b1; req_write_b = 1'b0; req_addr_b = 32'h10;
    @(posedge clk);
    #1 req_valid_b = 1'b0;
    repeat (5) @(negedge clk);
    chk("drain_busy", busy_b, 1);
    rst_b = 1'b1;
    #1;
    chk("drain_rst_ready", req_ready_b, 1);
    chk("drain_rst_busy", busy_b, 0);
    chk("drain_rst_rdata", rsp_rdata_b, 0);
    @(negedge clk);
    rst_b = 1'b0;
    repeat (6) @(negedge clk);
    chk("drain_no_rsp", rsps_b - r0, 0);
    run_b(32'h0, lat, rdb);
    chk("post_rst_lat", lat, 8);
    chk("post_rst_rdata", rdb, B_LD0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
